// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Four-requester round-robin write arbiter that feeds a single
//               downstream fifo. Winners keep the write port for up to BURST
//               consecutive words. Grants are combinational and are
//               suppressed while the fifo is full. A saturating counter
//               records backpressure cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   req_data,
    input  logic [3:0]           enable,
    input  logic                 fifo_full,
    output logic [3:0]           gnt,
    output logic                 fifo_wr_en,
    output logic [WIDTH-1:0]     fifo_data,
    output logic [1:0]           owner,
    output logic                 busy,
    output logic [15:0]          stall_cnt
);

    // Beat count value held in r_beat_cnt while the final beat of a burst
    // is being granted.
    localparam logic [3:0] c_LAST_BEAT   = 4'(BURST - 1);
    // A single-word burst never leaves IDLE; every grant rotates at once.
    localparam bit         c_SINGLE_BEAT = (BURST == 1);
    localparam logic [15:0] c_STALL_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         r_owner;
    logic [3:0]         r_beat_cnt;
    logic               r_busy;
    logic [15:0]        r_stall_cnt;

    logic [3:0]             w_eligible;
    logic [3:0][WIDTH-1:0]  w_words;
    logic [1:0]             w_scan_idx;
    logic [1:0]             w_pick_idx;
    logic                   w_pick_vld;
    logic [1:0]             w_gnt_idx;
    logic                   w_gnt_vld;

    assign w_eligible = req & enable;
    assign w_words    = req_data;

    // Round-robin search: first eligible index at or above rr_ptr, modulo 4.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = r_rr_ptr;
        w_scan_idx = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_scan_idx = r_rr_ptr + 2'(k);
            if (w_eligible[w_scan_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_scan_idx;
            end
        end
    end

    // Grant decision for this cycle; reset and a full fifo both veto it so
    // the fifo can never be written while full or during reset.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_owner;
        if (!rst && !fifo_full) begin
            if (r_state == S_IDLE) begin
                if (w_pick_vld) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_pick_idx;
                end
            end else if (w_eligible[r_owner]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = r_owner;
            end
        end
    end

    assign gnt        = w_gnt_vld ? (4'b0001 << w_gnt_idx) : 4'b0000;
    assign fifo_wr_en = w_gnt_vld;
    assign fifo_data  = w_gnt_vld ? w_words[w_gnt_idx] : '0;

    // Burst state machine: owner selection, beat counting and rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 2'd0;
            r_owner    <= 2'd0;
            r_beat_cnt <= 4'd0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_owner    <= w_gnt_idx;
                        r_beat_cnt <= 4'd1;
                        if (c_SINGLE_BEAT) begin
                            r_rr_ptr <= w_gnt_idx + 2'd1;
                        end else begin
                            r_state <= S_BURST;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (!w_eligible[r_owner]) begin
                        // Owner withdrew mid-burst: this cycle is lost and
                        // the pointer moves past the abandoned owner.
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= r_owner + 2'd1;
                    end else if (!fifo_full) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_rr_ptr <= r_owner + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Backpressure counter: cycles with pending eligible work but a full
    // fifo; saturates rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if ((|w_eligible) && fifo_full && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign owner     = r_owner;
    assign busy      = r_busy;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data word width, which SHALL equal the WIDTH of the downstream fifo.
REQ-002 The block SHALL have parameter BURST, default 4, legal range 1..15, the maximum consecutive words granted to one requester before rotation.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  4  per-requester write request; requester k holds req[k] and its data until it samples gnt[k]=1.
REQ-007 req_data  input  4*WIDTH  requester k word at bits [k*WIDTH +: WIDTH].
REQ-008 enable  input  4  per-requester enable mask; 0 excludes that requester.
REQ-009 fifo_full  input  1  full flag from the downstream fifo.
REQ-010 gnt  output  4  combinational one-hot grant; gnt[k]=1 means requester k's word is written at this rising edge.
REQ-011 fifo_wr_en  output  1  combinational, equal to OR of gnt.
REQ-012 fifo_data  output  WIDTH  combinational, equal to the granted requester's word, all-zero when no grant.
REQ-013 owner  output  2  registered index of the current or most recent burst owner.
REQ-014 busy  output  1  registered, 1 while the state is BURST.
REQ-015 stall_cnt  output  16  registered, saturating backpressure cycle counter.

Function
REQ-016 eligible SHALL equal req AND enable.
REQ-017 The state machine SHALL have exactly two states: IDLE and BURST.
REQ-018 In IDLE with fifo_full=0 and eligible nonzero, the block SHALL grant the first eligible index found by searching upward from rr_ptr, modulo 4.
REQ-019 That IDLE grant SHALL load owner with the winner and set beat_cnt=1.
REQ-020 After that IDLE grant the state SHALL go to BURST, except when BURST=1: then it SHALL stay IDLE and set rr_ptr=winner+1 mod 4.
REQ-021 In BURST with eligible[owner]=1 and fifo_full=0, the block SHALL assert gnt[owner] and increment beat_cnt.
REQ-022 When that BURST grant is beat number BURST, the state SHALL go to IDLE and rr_ptr SHALL become owner+1 mod 4.
REQ-023 In BURST with eligible[owner]=1 and fifo_full=1, the block SHALL issue no grant, hold beat_cnt, and remain in BURST.
REQ-024 In BURST with eligible[owner]=0, the block SHALL issue no grant, go to IDLE, and set rr_ptr=owner+1 mod 4; that cycle is a lost grant cycle.
REQ-025 Requests from non-owners in BURST SHALL be ignored.
REQ-026 gnt SHALL never be asserted when fifo_full=1 or rst=1, so the fifo is never written while full.
REQ-027 gnt SHALL have at most one bit set.
REQ-028 gnt SHALL only be set for an eligible requester.
REQ-029 Grant latency SHALL be zero cycles: the word is consumed at the same edge on which gnt is high.
REQ-030 stall_cnt SHALL increment each cycle in which eligible is nonzero and fifo_full=1.
REQ-031 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-032 beat_cnt SHALL be 4 bits wide, and rr_ptr and owner SHALL be 2 bits wide; index arithmetic wraps modulo 4.

Reset
REQ-033 While rst=1, independent of clk, the block SHALL hold state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, stall_cnt=0 and busy=0.
REQ-034 While rst=1, gnt=0, fifo_wr_en=0 and fifo_data=0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst with no partial-state carryover.
REQ-036 The first grant after reset SHALL search upward from index 0.

Verification
REQ-037 BURST=4, req=4'b1111, enable=4'b1111, fifo_full=0 held 16 cycles -> gnt index sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3; fifo_wr_en=1 every cycle; fifo_data matches each word.
REQ-038 Only req[2] held, fifo_full=1 for 3 cycles after the 2nd beat -> gnt low 3 cycles, busy=1, stall_cnt=3, then 2 more beats, then IDLE with rr_ptr=3.
REQ-039 req=4'b0011, requester 0 drops req after beat 2 -> one cycle with no grant, then the next grant goes to requester 1.
REQ-040 enable=4'b1010, req=4'b1111, BURST=1 -> grants alternate 1,3,1,3; gnt[0] and gnt[2] never asserted.
REQ-041 rst pulsed asynchronously between edges during beat 3 of requester 1 -> gnt/fifo_wr_en drop immediately, busy=0, stall_cnt=0; after release with req=4'b1111 the first grant goes to 0.
REQ-042 eligible nonzero with fifo_full=1 held 65540 cycles -> stall_cnt reaches 16'hFFFF and stays there; zero grants issued.
